// File: rtl/line_window_pkg.sv
// Shared width helper and window packing offset for the line window buffer.
// Kept in one place so the top and line delays agree on counter/pointer widths.
package line_window_pkg;

  // Index width for a counter over n entries, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // LSB of window element (r,c): r=0 is the oldest line, c=0 the oldest column.
  function automatic int unsigned win_lsb(input int unsigned r, input int unsigned c,
                                          input int unsigned k, input int unsigned dw);
    return ((r * k) + c) * dw;
  endfunction

endpackage

// File: rtl/line_delay.sv
// Enable-gated circular-buffer delay of DEPTH accepted words.
// Read-before-write: o_data is the word accepted exactly DEPTH enables ago.
module line_delay
  import line_window_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 640
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  localparam int PW = idx_width(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_ptr;

  assign o_data = r_mem[r_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

  // Storage carries no reset so it can map onto a RAM.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[r_ptr] <= i_data;
    end
  end

endmodule

// File: rtl/line_window_buffer.sv
// Raster-scan KxK sliding window generator built from K-1 line delays.
// Emits only windows fully inside the frame, tagged with the centre coordinate.
module line_window_buffer
  import line_window_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int KERNEL_SIZE  = 3
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       valid,
  input  logic                                       sof,
  input  logic [DATA_WIDTH-1:0]                      data_in,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window_out,
  output logic                                       window_valid,
  output logic [idx_width(IMAGE_WIDTH)-1:0]          center_col,
  output logic [idx_width(IMAGE_HEIGHT)-1:0]         center_row,
  output logic                                       frame_done
);

  localparam int K    = KERNEL_SIZE;
  localparam int CW   = idx_width(IMAGE_WIDTH);
  localparam int RW   = idx_width(IMAGE_HEIGHT);
  localparam int HALF = (K - 1) / 2;

  // w_tap[k] is the pixel from k lines earlier than data_in.
  logic [DATA_WIDTH-1:0] w_tap [K];
  logic [DATA_WIDTH-1:0] r_win [K][K];
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [CW-1:0]         w_pix_col;
  logic [RW-1:0]         w_pix_row;
  logic                  w_last_col;
  logic                  w_last_row;
  logic                  w_win_ok;

  assign w_tap[0] = data_in;

  for (genvar k = 1; k < K; k++) begin : g_delay
    line_delay #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (IMAGE_WIDTH)
    ) u_line_delay (
      .clk   (clk),
      .reset (reset),
      .i_en  (valid),
      .i_data(w_tap[k-1]),
      .o_data(w_tap[k])
    );
  end

  // Position of the pixel on data_in; sof forces it to (0,0).
  assign w_pix_col  = sof ? '0 : r_col;
  assign w_pix_row  = sof ? '0 : r_row;
  assign w_last_col = (w_pix_col == CW'(IMAGE_WIDTH - 1));
  assign w_last_row = (w_pix_row == RW'(IMAGE_HEIGHT - 1));
  assign w_win_ok   = (w_pix_col >= CW'(K - 1)) && (w_pix_row >= RW'(K - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (valid) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : w_pix_row + 1'b1;
      end else begin
        r_col <= w_pix_col + 1'b1;
        r_row <= w_pix_row;
      end
    end
  end

  // Each row shifts toward column 0; the newest column enters at K-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else if (valid) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          r_win[r][c] <= r_win[r][c+1];
        end
        r_win[r][K-1] <= w_tap[K-1-r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      center_col   <= '0;
      center_row   <= '0;
    end else begin
      window_valid <= valid && w_win_ok;
      frame_done   <= valid && w_last_col && w_last_row;
      if (valid) begin
        center_col <= w_pix_col - CW'(HALF);
        center_row <= w_pix_row - RW'(HALF);
      end
    end
  end

  always_comb begin
    window_out = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        window_out[win_lsb(r, c, K, DATA_WIDTH) +: DATA_WIDTH] = r_win[r][c];
      end
    end
  end

endmodule

// File: doc/line_window_buffer.md
LINE_WINDOW_BUFFER -- requirements
Module: line_window_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, pixel word width in bits.
REQ-002 SHALL have parameter IMAGE_WIDTH, default 640, pixels per line (>= KERNEL_SIZE).
REQ-003 SHALL have parameter IMAGE_HEIGHT, default 480, lines per frame (>= KERNEL_SIZE).
REQ-004 SHALL have parameter KERNEL_SIZE, default 3, window edge length (odd, 3..7).
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port valid  input  1  data_in carries a pixel this cycle.
REQ-008 SHALL have port sof  input  1  qualified by valid; marks pixel (0,0) of a frame.
REQ-009 SHALL have port data_in  input  DATA_WIDTH  raster-order pixel.
REQ-010 SHALL have port window_out  output  KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH  packed KxK window.
REQ-011 SHALL have port window_valid  output  1  window_out holds a complete in-frame window.
REQ-012 SHALL have port center_col  output  clog2(IMAGE_WIDTH)  column of window centre pixel.
REQ-013 SHALL have port center_row  output  clog2(IMAGE_HEIGHT)  row of window centre pixel.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after last pixel of a frame accepted.

Function
REQ-015 SHALL hold KERNEL_SIZE-1 line delays, each exactly IMAGE_WIDTH accepted pixels deep, chained so tap k emits the pixel from k lines earlier.
REQ-016 SHALL advance line delays, window registers and counters only on cycles with valid=1; valid=0 freezes all state and outputs except window_valid and frame_done.
REQ-017 SHALL shift each window row left by one column per accepted pixel, loading the new column from data_in (bottom row) and line-delay taps (upper rows).
REQ-018 SHALL pack element (r,c) at bits [((r*K)+c+1)*DATA_WIDTH-1 : ((r*K)+c)*DATA_WIDTH]; r=0 oldest line, c=0 oldest column.
REQ-019 SHALL keep col counter 0..IMAGE_WIDTH-1 and row counter 0..IMAGE_HEIGHT-1 of the accepted pixel; col wraps to 0 and increments row; at (H-1,W-1) both wrap to 0.
REQ-020 SHALL, when valid=1 and sof=1, treat that pixel as (0,0) regardless of counter state, overriding wrap.
REQ-021 SHALL assert window_valid for exactly one cycle, on the cycle after accepting pixel (row,col) with row >= K-1 and col >= K-1; otherwise 0.
REQ-022 SHALL drive center_row=row-(K-1)/2, center_col=col-(K-1)/2 of the triggering pixel, registered alongside window_valid.
REQ-023 SHALL pulse frame_done the cycle after accepting (H-1,W-1), coincident with the final window_valid.
REQ-024 SHALL NOT produce windows spanning line boundaries (col < K-1 suppressed) or frame boundaries (row < K-1 suppressed); no border padding.
REQ-025 SHALL support back-to-back frames at one pixel/cycle with no bubble.

Reset
REQ-026 SHALL, on reset=1 at a clock edge, clear col, row, window registers, window_out, center_col, center_row, window_valid and frame_done to 0; reset takes priority over valid.
REQ-027 SHALL NOT require clearing line-delay storage; stale contents never reach a valid window after reset (guaranteed by REQ-021).
REQ-028 SHALL, on reset mid-frame, restart at (0,0) with the next accepted pixel.

Structure
REQ-029 SHALL place the window index/offset function and clog2 width constants in shared package line_window_pkg.
REQ-030 SHALL implement each line delay as sub-module line_delay (DATA_WIDTH, DEPTH; enable-gated, RAM-inferable circular buffer with read-before-write pointer, no reset on storage).

Verification (DATA_WIDTH=8, IMAGE_WIDTH=8, IMAGE_HEIGHT=6, KERNEL_SIZE=3, pixel = row*16+col)
REQ-031 Continuous frame, valid=1 -> first window_valid after pixel (2,2), window rows {0x00,01,02 / 10,11,12 / 20,21,22}, centre (1,1); 24 windows total; frame_done with last.
REQ-032 Random valid gaps (50%) -> identical window sequence and centres to REQ-031, each window_valid one cycle after its triggering pixel.
REQ-033 Two frames back-to-back, second pixels +0x80 -> no window mixes frames; 48 windows; two frame_done pulses.
REQ-034 Reset asserted at pixel (3,4), then fresh frame with sof -> outputs 0 during reset; next frame matches REQ-031 exactly.
REQ-035 sof asserted at pixel index 20 of a frame -> counters resynchronise to (0,0) there; no window_valid until new (2,2).
REQ-036 valid=0 for 10 cycles mid-line -> window_out, centres constant; window_valid and frame_done low.
